pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised fetch program-counter unit for the 5-stage MIPS-Lite pipeline; successor to the single-register PC.
- Adds configurable width, reset vector and step, plus prioritised redirects (exception, branch, jump).
- A redirect that arrives during a hazard stall is held in a pending slot so it is never lost.
- Halt is sticky, and the block exposes the next-PC value to the IF stage.

Parameters:
- DATA, mips_pkg::DATA (32): PC width in bits.
- RESET_VEC, 0: PC value loaded on reset.
- STEP, 4: sequential increment.
- ALIGN_BITS, 2: number of low PC bits that must be zero.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; reset==0 puts the block in reset immediately.
- hazardDetected  in  1  stall request from the hazard unit.
- haltSignal  in  1  halt request from the decode stage.
- excTaken  in  1  exception redirect request.
- excVector  in  DATA  exception target.
- branchTaken  in  1  branch redirect request.
- branchTarget  in  DATA  branch target.
- jumpTaken  in  1  jump redirect request.
- jumpTarget  in  DATA  jump target.
- pc  out  DATA  current fetch address (registered).
- pcNext  out  DATA  value pc takes at the next edge (combinational).
- pcValid  out  1  fetch at pc is valid this cycle.
- halted  out  1  block is in HALTED.
- redirectPending  out  1  pending slot is occupied.
- misalignErr  out  1  one-cycle registered pulse when a loaded target had nonzero low bits.

Behaviour:
- Reset (reset==0, async) sets:
  - pc=RESET_VEC, state=RUN
  - pending slot empty, redirectPending=0
  - halted=0, misalignErr=0
- Reset asserted mid-stall or mid-halt discards the pending redirect and returns to RUN.
- Encoding: FSM states RUN, STALL, HALTED are encoded in the package enum pc_state_t.
- pcValid = (state==RUN) && !hazardDetected.
- Redirect selection:
  - Live priority: excTaken > branchTaken > jumpTaken > sequential (pc+STEP).
  - Sequential add wraps modulo 2^DATA, e.g. 32'hFFFF_FFFC+4 -> 0.
- RUN, hazardDetected=0: pc <= selected value; stay in RUN.
- RUN, hazardDetected=1:
  - pc holds; state goes to STALL.
  - Any live redirect is captured into the pending slot (target and kind).
- STALL, redirects arriving:
  - A live exc always overwrites the pending slot.
  - A live branch/jump is captured only if the slot is empty.
  - pc holds.
- STALL, on the first cycle hazardDetected=0:
  - Priority: live exc > pending > live branch > live jump > pc+STEP.
  - pc <= that value; pending slot cleared; state goes to RUN.
- Halt:
  - haltSignal=1 in RUN or STALL: next edge pc holds, state goes to HALTED, halted=1, pending slot cleared.
  - Halt beats exception, redirect and hazard in the same cycle.
  - HALTED is exited only by reset; all inputs are ignored.
- Alignment:
  - Any redirect target with pc[ALIGN_BITS-1:0]!=0 loads with those bits forced to 0.
  - misalignErr=1 for the cycle after the load.
- pcNext always equals the value pc will hold after the coming edge; in STALL/HALTED it equals pc.

Optional Feature:
- Macro: PC_PERF_EN.
- When defined, two extra output ports exist:
  - stallCycles [31:0]: counts cycles in STALL.
  - redirectCount [31:0]: counts redirects actually loaded into pc.
  - Both are reset to 0 by reset and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- mips_pkg holds:
  - DATA
  - typedef enum pc_state_t {RUN, STALL, HALTED}
  - typedef enum redir_kind_t {R_NONE, R_JUMP, R_BRANCH, R_EXC}
  - typedef struct redir_t {redir_kind_t kind; logic [DATA-1:0] target;}
- Sub-module pc_redirect_sel: combinational priority select plus alignment, returning the next pc and the misalign flag.
- The FSM, pending slot and counters live in pc_unit.

Test Plan:
- Reset release, no hazard, 4 cycles -> pc 0,4,8,12,16; pcValid=1 from the first cycle after reset.
- Start at pc=8; branchTaken target 0x100 and jumpTaken target 0x200 in the same cycle -> pc=0x100.
  - Same cycle with excTaken vector 0x80 also set -> pc=0x80.
- At pc=0x20, hazardDetected=1 for 3 cycles with branchTaken target 0x40 on cycle 1:
  - pc holds 0x20 and redirectPending=1.
  - On release pc=0x40, redirectPending=0.
- Stall holding pending branch 0x40, then excTaken 0x80 mid-stall -> on release pc=0x80.
  - Variant: live jump 0x60 on the release cycle with pending 0x40 -> pc=0x40.
- haltSignal=1 together with excTaken at pc=0x30 -> pc stays 0x30, halted=1 for 10 cycles.
  - Then reset pulse low -> pc=RESET_VEC, halted=0.
- Start at pc=0xFFFF_FFFC -> next pc=0.
  - Separately, jumpTarget 0x103 -> pc=0x100 and misalignErr pulses for 1 cycle.
  - With PC_PERF_EN, 3 stall cycles plus 1 redirect -> stallCycles=3, redirectCount=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-Lite fetch path.
package mips_pkg;

  localparam int DATA = 32;

  typedef enum logic [1:0] {RUN, STALL, HALTED} pc_state_t;

  typedef enum logic [1:0] {R_NONE, R_JUMP, R_BRANCH, R_EXC} redir_kind_t;

  typedef struct packed {
    redir_kind_t     kind;
    logic [DATA-1:0] target;
  } redir_t;

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority select of the next fetch address (exc > pending > branch > jump > pc+STEP)
// with forced alignment of redirect targets.
module pc_redirect_sel #(
  parameter int DATA       = mips_pkg::DATA,
  parameter int STEP       = 4,
  parameter int ALIGN_BITS = 2
) (
  input  logic [DATA-1:0] pc,
  input  logic            exc_taken,
  input  logic [DATA-1:0] exc_vector,
  input  logic            pend_valid,
  input  logic [DATA-1:0] pend_target,
  input  logic            branch_taken,
  input  logic [DATA-1:0] branch_target,
  input  logic            jump_taken,
  input  logic [DATA-1:0] jump_target,
  output logic [DATA-1:0] next_pc,
  output logic            misalign
);

  localparam logic [DATA-1:0] LOW_MASK = {DATA{1'b1}} >> (DATA - ALIGN_BITS);

  logic [DATA-1:0] target;
  logic            redirect;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    target   = '0;
    redirect = 1'b1;
    if (exc_taken)         target = exc_vector;
    else if (pend_valid)   target = pend_target;
    else if (branch_taken) target = branch_target;
    else if (jump_taken)   target = jump_target;
    else                   redirect = 1'b0;
  end

  assign next_pc  = redirect ? (target & ~LOW_MASK) : pc + DATA'(STEP);
  assign misalign = redirect && ((target & LOW_MASK) != '0);

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with prioritised redirects, stall-safe pending slot and sticky halt.
// Optional PC_PERF_EN adds saturating stall-cycle and redirect counters.
module pc_unit
  import mips_pkg::*;
#(
  parameter int              DATA       = mips_pkg::DATA,
  parameter logic [DATA-1:0] RESET_VEC  = '0,
  parameter int              STEP       = 4,
  parameter int              ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hazardDetected,
  input  logic            haltSignal,
  input  logic            excTaken,
  input  logic [DATA-1:0] excVector,
  input  logic            branchTaken,
  input  logic [DATA-1:0] branchTarget,
  input  logic            jumpTaken,
  input  logic [DATA-1:0] jumpTarget,
  output logic [DATA-1:0] pc,
  output logic [DATA-1:0] pcNext,
  output logic            pcValid,
  output logic            halted,
  output logic            redirectPending,
  output logic            misalignErr
`ifdef PC_PERF_EN
  ,
  output logic [31:0]     stallCycles,
  output logic [31:0]     redirectCount
`endif
);

  pc_state_t       state, state_next;
  redir_kind_t     pend_kind, pend_kind_next;
  logic [DATA-1:0] pend_target, pend_target_next;
  logic            pend_valid;
  logic            hold;
  logic [DATA-1:0] sel_pc;
  logic            sel_misalign;

  assign pend_valid = (pend_kind != R_NONE);

  pc_redirect_sel #(
    .DATA       (DATA),
    .STEP       (STEP),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_sel (
    .pc            (pc),
    .exc_taken     (excTaken),
    .exc_vector    (excVector),
    .pend_valid    (pend_valid),
    .pend_target   (pend_target),
    .branch_taken  (branchTaken),
    .branch_target (branchTarget),
    .jump_taken    (jumpTaken),
    .jump_target   (jumpTarget),
    .next_pc       (sel_pc),
    .misalign      (sel_misalign)
  );

  // RUN and STALL share one rule set: the slot is always empty in RUN, so the
  // capture and release priorities collapse to the RUN behaviour there.
  always_comb begin
    state_next       = state;
    hold             = 1'b1;
    pend_kind_next   = pend_kind;
    pend_target_next = pend_target;
    case (state)
      RUN, STALL: begin
        if (haltSignal) begin
          state_next     = HALTED;
          pend_kind_next = R_NONE;
        end else if (hazardDetected) begin
          state_next = STALL;
          if (excTaken) begin
            pend_kind_next   = R_EXC;
            pend_target_next = excVector;
          end else if (!pend_valid && branchTaken) begin
            pend_kind_next   = R_BRANCH;
            pend_target_next = branchTarget;
          end else if (!pend_valid && jumpTaken) begin
            pend_kind_next   = R_JUMP;
            pend_target_next = jumpTarget;
          end
        end else begin
          state_next     = RUN;
          hold           = 1'b0;
          pend_kind_next = R_NONE;
        end
      end
      default: ;
    endcase
  end

  assign pcNext          = hold ? pc : sel_pc;
  assign pcValid         = (state == RUN) && !hazardDetected;
  assign halted          = (state == HALTED);
  assign redirectPending = pend_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= RESET_VEC;
      pend_kind   <= R_NONE;
      // NOTE: the slot target is reset too so a stale address never leaks out after reset.
      pend_target <= '0;
      misalignErr <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state       <= state_next;
      pc          <= pcNext;
      pend_kind   <= pend_kind_next;
      pend_target <= pend_target_next;
      misalignErr <= !hold && sel_misalign;
    end
  end

`ifdef PC_PERF_EN
  logic loaded_redirect;
  assign loaded_redirect = !hold && (excTaken || pend_valid || branchTaken || jumpTaken);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCycles   <= '0;
      redirectCount <= '0;
    end else begin
      if (state == STALL && stallCycles != '1)  stallCycles   <= stallCycles + 32'd1;
      if (loaded_redirect && redirectCount != '1) redirectCount <= redirectCount + 32'd1;
    end
  end
`endif

endmodule
